// File: rtl/riscv_dmem_resp_pkg.sv
// ---------------------------------------------------------------------------
// riscv_dmem_resp_pkg
// Shared definitions for the data-memory responder and its RAM:
//   - dmem_state_e : 2-bit FSM encodings DMEM_IDLE / DMEM_WAIT / DMEM_RESP
//   - DMEM_WAIT_W  : width of the wait-state counter (WAIT_CYCLES 0..15)
//   - DMEM_LANES   : number of byte lanes in a 32-bit data word
// ---------------------------------------------------------------------------
package riscv_dmem_resp_pkg;

    typedef enum logic [1:0] {
        DMEM_IDLE = 2'd0,
        DMEM_WAIT = 2'd1,
        DMEM_RESP = 2'd2
    } dmem_state_e;

    localparam int DMEM_WAIT_W = 4;
    localparam int DMEM_LANES  = 4;

endpackage

// File: rtl/riscv_dmem_ram.sv
// ---------------------------------------------------------------------------
// riscv_dmem_ram
// Single-port DEPTH x 32 RAM with synchronous read and per-byte write enables.
//
// Ports:
//   clk   in   clock, all state on rising edge
//   en    in   port enable; with we==0 it performs a read, otherwise a write
//   we    in   byte-lane write enables (bit n -> wdata[8n+7:8n])
//   addr  in   word index
//   wdata in   write data
//   rdata out  registered read data; only a read access updates it, so the
//              last read value is held across writes and idle cycles
// ---------------------------------------------------------------------------
module riscv_dmem_ram
    import riscv_dmem_resp_pkg::*;
#(
    parameter int DEPTH = 1024
) (
    input  logic                     clk,
    input  logic                     en,
    input  logic [DMEM_LANES-1:0]    we,
    input  logic [$clog2(DEPTH)-1:0] addr,
    input  logic [31:0]              wdata,
    output logic [31:0]              rdata
);

    logic [31:0] r_mem [DEPTH];
    logic [31:0] r_rdata;

    always_ff @(posedge clk) begin
        if (en) begin
            for (int lane = 0; lane < DMEM_LANES; lane++) begin
                if (we[lane]) begin
                    r_mem[addr][8*lane +: 8] <= wdata[8*lane +: 8];
                end
            end
        end
    end

    // Read register is only loaded by a pure read so that the responder can
    // present it directly as held read data.
    always_ff @(posedge clk) begin
        if (en && (we == '0)) begin
            r_rdata <= r_mem[addr];
        end
    end

    assign rdata = r_rdata;

endmodule

// File: rtl/riscv_dmem_resp.sv
// ---------------------------------------------------------------------------
// riscv_dmem_resp
// Data-memory responder for the data_bif bus. Captures one word read or
// byte-masked write per request, waits WAIT_CYCLES, then acknowledges for a
// single cycle. Reads return registered RAM data in the ack cycle.
//
// Optional feature macro: RISCV_DMEM_BOUNDS_EN
//   defined   : addresses outside [BASE_ADDR, BASE_ADDR+DEPTH*4) ack with
//               err=1, do not write the RAM and return rdata=0 for reads
//   undefined : no range check, addresses alias modulo DEPTH, err tied 0
//
// Ports:
//   clk             in   clock
//   rst             in   synchronous active-high reset
//   data_bif_addr   in   byte address (bits [1:0] ignored)
//   data_bif_req    in   request level, held until ack
//   data_bif_rnw    in   1=read, 0=write
//   data_bif_wmask  in   byte-lane write enables
//   data_bif_wdata  in   write data
//   data_bif_rdata  out  read data, valid in read ack cycle, held after
//   data_bif_ack    out  one-cycle completion pulse
//   data_bif_err    out  error qualifier, valid with ack
// ---------------------------------------------------------------------------
module riscv_dmem_resp
    import riscv_dmem_resp_pkg::*;
#(
    parameter int          DEPTH       = 1024,
    parameter int          WAIT_CYCLES = 0,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [31:0]           data_bif_addr,
    input  logic                  data_bif_req,
    input  logic                  data_bif_rnw,
    input  logic [DMEM_LANES-1:0] data_bif_wmask,
    input  logic [31:0]           data_bif_wdata,
    output logic [31:0]           data_bif_rdata,
    output logic                  data_bif_ack,
    output logic                  data_bif_err
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [DMEM_WAIT_W-1:0] WAIT_LOAD =
        (WAIT_CYCLES > 0) ? DMEM_WAIT_W'(WAIT_CYCLES - 1) : '0;

    dmem_state_e            r_state;
    dmem_state_e            w_state_next;
    logic [DMEM_WAIT_W-1:0] r_wait_cnt;
    logic [DMEM_WAIT_W-1:0] w_wait_cnt_next;

    // Holding registers for the captured transaction
    logic [AW-1:0]          r_idx;
    logic                   r_rnw;
    logic [DMEM_LANES-1:0]  r_wmask;
    logic [31:0]            r_wdata;
    logic                   r_oob;

    // Forces data_bif_rdata to zero after reset and after an out-of-range read
    logic                   r_rd_zero;

    logic [31:0]            w_off;
    logic [AW-1:0]          w_in_idx;
    logic                   w_oob;
    logic                   w_capture;
    logic                   w_rd_issue;
    logic                   w_rd_oob;
    logic                   w_ram_en;
    logic [DMEM_LANES-1:0]  w_ram_we;
    logic [AW-1:0]          w_ram_addr;
    logic [31:0]            w_ram_rdata;
    logic                   w_unused;

    // Offset from the window base; subtraction wraps for addresses below
    // BASE_ADDR so one unsigned compare covers both ends of the window.
    assign w_off    = data_bif_addr - BASE_ADDR;
    assign w_in_idx = w_off[AW+1:2];

`ifdef RISCV_DMEM_BOUNDS_EN
    localparam logic [32:0] SPAN = 33'(DEPTH) << 2;
    assign w_oob        = ({1'b0, w_off} >= SPAN);
    assign data_bif_err = data_bif_ack & r_oob;
    assign w_unused     = ^w_off[1:0];
`else
    assign w_oob        = 1'b0;
    assign data_bif_err = 1'b0;
    assign w_unused     = ^{w_off[31:AW+2], w_off[1:0]};
`endif

    // ------------------------------------------------------------------
    // FSM state register and wait counter
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= DMEM_IDLE;
            r_wait_cnt <= '0;
        end else begin
            r_state    <= w_state_next;
            r_wait_cnt <= w_wait_cnt_next;
        end
    end

    // ------------------------------------------------------------------
    // Next state, RAM control and ack
    // The RAM read is issued on the edge that enters RESP so its registered
    // output is valid during the ack cycle. From IDLE (WAIT_CYCLES=0) the
    // capture happens on that same edge, so the live bus address is used.
    // The write is issued during RESP and lands on the edge that ends it.
    // ------------------------------------------------------------------
    always_comb begin
        w_state_next    = r_state;
        w_wait_cnt_next = r_wait_cnt;
        w_capture       = 1'b0;
        w_rd_issue      = 1'b0;
        w_rd_oob        = 1'b0;
        w_ram_en        = 1'b0;
        w_ram_we        = '0;
        w_ram_addr      = r_idx;
        data_bif_ack    = 1'b0;

        case (r_state)
            DMEM_IDLE: begin
                w_ram_addr = w_in_idx;
                if (data_bif_req) begin
                    w_capture       = 1'b1;
                    w_wait_cnt_next = WAIT_LOAD;
                    if (WAIT_CYCLES > 0) begin
                        w_state_next = DMEM_WAIT;
                    end else begin
                        w_state_next = DMEM_RESP;
                        w_rd_issue   = data_bif_rnw;
                        w_rd_oob     = w_oob;
                    end
                end
            end
            DMEM_WAIT: begin
                if (r_wait_cnt == '0) begin
                    w_state_next = DMEM_RESP;
                    w_rd_issue   = r_rnw;
                    w_rd_oob     = r_oob;
                end else begin
                    w_wait_cnt_next = r_wait_cnt - 1'b1;
                end
            end
            DMEM_RESP: begin
                data_bif_ack = 1'b1;
                w_state_next = DMEM_IDLE;
                // An all-zero mask must not enable the RAM: with we==0 the
                // RAM would treat it as a read and disturb the held rdata.
                if (!r_rnw && !r_oob && (r_wmask != '0)) begin
                    w_ram_en = 1'b1;
                    w_ram_we = r_wmask;
                end
            end
            default: begin
                w_state_next = DMEM_IDLE;
            end
        endcase

        if (w_rd_issue && !w_rd_oob) begin
            w_ram_en = 1'b1;
        end

        // Reset abandons whatever is in flight: no capture, no RAM access,
        // no acknowledge.
        if (rst) begin
            w_capture    = 1'b0;
            w_rd_issue   = 1'b0;
            w_ram_en     = 1'b0;
            w_ram_we     = '0;
            data_bif_ack = 1'b0;
        end
    end

    // ------------------------------------------------------------------
    // Holding registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_idx   <= '0;
            r_rnw   <= 1'b1;
            r_wmask <= '0;
            r_wdata <= '0;
            r_oob   <= 1'b0;
        end else if (w_capture) begin
            r_idx   <= w_in_idx;
            r_rnw   <= data_bif_rnw;
            r_wmask <= data_bif_wmask;
            r_wdata <= data_bif_wdata;
            r_oob   <= w_oob;
        end
    end

    // Updated on the same edge as the RAM read register so both change
    // together at the start of the read ack cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rd_zero <= 1'b1;
        end else if (w_rd_issue) begin
            r_rd_zero <= w_rd_oob;
        end
    end

    assign data_bif_rdata = r_rd_zero ? 32'h0 : w_ram_rdata;

    riscv_dmem_ram #(
        .DEPTH (DEPTH)
    ) u_ram (
        .clk   (clk),
        .en    (w_ram_en),
        .we    (w_ram_we),
        .addr  (w_ram_addr),
        .wdata (r_wdata),
        .rdata (w_ram_rdata)
    );

endmodule

// File: tb/tb_riscv_dmem_resp.sv
// ---------------------------------------------------------------------------
// tb_riscv_dmem_resp
// Directed bench for riscv_dmem_resp. Three instances with WAIT_CYCLES of
// 0, 1 and 3 share clock and reset; index 0/1/2 selects the instance.
// Build with RISCV_DMEM_BOUNDS_EN to exercise the range-check expectations.
// ---------------------------------------------------------------------------
module tb_riscv_dmem_resp;

    logic        clk = 1'b0;
    logic        rst;
    logic        req   [3];
    logic        rnw   [3];
    logic [31:0] addr  [3];
    logic [3:0]  wmask [3];
    logic [31:0] wdata [3];
    logic [31:0] rdata [3];
    logic        ack   [3];
    logic        err   [3];

    int n_cmp  = 0;
    int n_fail = 0;

`ifdef RISCV_DMEM_BOUNDS_EN
    localparam logic BOUNDS = 1'b1;
`else
    localparam logic BOUNDS = 1'b0;
`endif

    always #5 clk = ~clk;

    riscv_dmem_resp #(.DEPTH(1024), .WAIT_CYCLES(0), .BASE_ADDR(32'h0)) u_w0 (
        .clk(clk), .rst(rst), .data_bif_addr(addr[0]), .data_bif_req(req[0]),
        .data_bif_rnw(rnw[0]), .data_bif_wmask(wmask[0]), .data_bif_wdata(wdata[0]),
        .data_bif_rdata(rdata[0]), .data_bif_ack(ack[0]), .data_bif_err(err[0]));

    riscv_dmem_resp #(.DEPTH(1024), .WAIT_CYCLES(1), .BASE_ADDR(32'h0)) u_w1 (
        .clk(clk), .rst(rst), .data_bif_addr(addr[1]), .data_bif_req(req[1]),
        .data_bif_rnw(rnw[1]), .data_bif_wmask(wmask[1]), .data_bif_wdata(wdata[1]),
        .data_bif_rdata(rdata[1]), .data_bif_ack(ack[1]), .data_bif_err(err[1]));

    riscv_dmem_resp #(.DEPTH(1024), .WAIT_CYCLES(3), .BASE_ADDR(32'h0)) u_w3 (
        .clk(clk), .rst(rst), .data_bif_addr(addr[2]), .data_bif_req(req[2]),
        .data_bif_rnw(rnw[2]), .data_bif_wmask(wmask[2]), .data_bif_wdata(wdata[2]),
        .data_bif_rdata(rdata[2]), .data_bif_ack(ack[2]), .data_bif_err(err[2]));

    function automatic int lat_of(input int d);
        return (d == 0) ? 1 : (d == 1) ? 2 : 4;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One complete request/ack handshake; req drops in the ack cycle.
    task automatic txn(input int d, input logic r, input logic [31:0] a,
                       input logic [3:0] m, input logic [31:0] wd,
                       output logic [31:0] rd, output logic e, output int lat);
        @(posedge clk); #1;
        req[d] = 1'b1; rnw[d] = r; addr[d] = a; wmask[d] = m; wdata[d] = wd;
        lat = 0;
        do begin
            @(posedge clk); #1;
            lat++;
        end while (!ack[d] && lat < 40);
        check("ack_seen", {31'b0, ack[d]}, 32'd1);
        req[d] = 1'b0;
        rd = rdata[d];
        e  = err[d];
        $display("txn dut%0d %s addr=%h wmask=%b wdata=%h rdata=%h err=%b lat=%0d",
                 d, r ? "RD" : "WR", a, m, wd, rd, e, lat);
    endtask

    task automatic wr_chk(input int d, input logic [31:0] a, input logic [3:0] m,
                          input logic [31:0] wd, input logic exp_err, input string tag);
        logic [31:0] rd;
        logic        e;
        int          lat;
        txn(d, 1'b0, a, m, wd, rd, e, lat);
        check({tag, "_lat"}, 32'(lat), 32'(lat_of(d)));
        check({tag, "_err"}, {31'b0, e}, {31'b0, exp_err});
    endtask

    task automatic rd_chk(input int d, input logic [31:0] a, input logic [31:0] exp_data,
                          input logic exp_err, input string tag);
        logic [31:0] rd;
        logic        e;
        int          lat;
        txn(d, 1'b1, a, 4'b0000, 32'h0, rd, e, lat);
        check({tag, "_lat"}, 32'(lat), 32'(lat_of(d)));
        check({tag, "_err"}, {31'b0, e}, {31'b0, exp_err});
        check({tag, "_data"}, rd, exp_data);
    endtask

    logic [31:0] vals [3];

    initial begin
        for (int i = 0; i < 3; i++) begin
            req[i] = 1'b0; rnw[i] = 1'b1; addr[i] = '0; wmask[i] = '0; wdata[i] = '0;
        end
        vals[0] = 32'h1111_0001; vals[1] = 32'h2222_0002; vals[2] = 32'h3333_0003;

        // Reset state
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        for (int i = 0; i < 3; i++) begin
            check("rst_ack",   {31'b0, ack[i]}, 32'd0);
            check("rst_err",   {31'b0, err[i]}, 32'd0);
            check("rst_rdata", rdata[i], 32'h0);
        end
        rst = 1'b0;

        // 1: basic write then read, zero wait states
        wr_chk(0, 32'h10, 4'b1111, 32'hDEAD_BEEF, 1'b0, "t1_wr");
        rd_chk(0, 32'h10, 32'hDEAD_BEEF, 1'b0, "t1_rd");

        // 2: byte masking and empty mask
        wr_chk(0, 32'h20, 4'b1111, 32'h1122_3344, 1'b0, "t2_pre");
        wr_chk(0, 32'h20, 4'b0101, 32'hAABB_CCDD, 1'b0, "t2_mask");
        rd_chk(0, 32'h20, 32'h11BB_33DD, 1'b0, "t2_rd");
        wr_chk(0, 32'h20, 4'b0000, 32'hFFFF_FFFF, 1'b0, "t2_m0");
        check("t2_rdata_held", rdata[0], 32'h11BB_33DD);
        rd_chk(0, 32'h20, 32'h11BB_33DD, 1'b0, "t2_rd2");

        // 3: WAIT_CYCLES=3, bus toggled while the read is in flight
        wr_chk(2, 32'h40, 4'b1111, 32'hCAFE_F00D, 1'b0, "t3_pre0");
        wr_chk(2, 32'h44, 4'b1111, 32'h1234_5678, 1'b0, "t3_pre1");
        @(posedge clk); #1;
        req[2] = 1'b1; rnw[2] = 1'b1; addr[2] = 32'h40;
        for (int c = 1; c <= 8; c++) begin
            @(posedge clk); #1;
            check($sformatf("t3_ack_c%0d", c), {31'b0, ack[2]}, {31'b0, (c == 4)});
            if (c <= 3) begin
                addr[2] = 32'h44; rnw[2] = ~rnw[2]; wmask[2] = 4'hF; wdata[2] = 32'hFFFF_0000;
            end
            if (c == 4) begin
                check("t3_rdata", rdata[2], 32'hCAFE_F00D);
                req[2] = 1'b0; rnw[2] = 1'b1;
            end
        end
        rd_chk(2, 32'h44, 32'h1234_5678, 1'b0, "t3_rd44");

        // 4: req held across three reads, WAIT_CYCLES=1 -> acks at 2, 5, 8
        for (int k = 0; k < 3; k++) begin
            wr_chk(1, 32'h80 + 32'(4 * k), 4'b1111, vals[k], 1'b0, "t4_pre");
        end
        @(posedge clk); #1;
        req[1] = 1'b1; rnw[1] = 1'b1; addr[1] = 32'h80;
        for (int c = 1; c <= 9; c++) begin
            @(posedge clk); #1;
            check($sformatf("t4_ack_c%0d", c), {31'b0, ack[1]},
                  {31'b0, (c == 2 || c == 5 || c == 8)});
            if (c == 2 || c == 5 || c == 8) begin
                check($sformatf("t4_rdata_c%0d", c), rdata[1], vals[(c - 2) / 3]);
                addr[1] = 32'h80 + 32'(4 * ((c - 2) / 3 + 1));
                if (c == 8) req[1] = 1'b0;
            end
        end

        // 5: reset during WAIT abandons a write
        wr_chk(2, 32'h60, 4'b1111, 32'h0BAD_F00D, 1'b0, "t5_pre");
        rd_chk(2, 32'h60, 32'h0BAD_F00D, 1'b0, "t5_rd0");
        @(posedge clk); #1;
        req[2] = 1'b1; rnw[2] = 1'b0; addr[2] = 32'h60; wmask[2] = 4'hF; wdata[2] = 32'h5555_5555;
        @(posedge clk); #1;
        req[2] = 1'b0;
        check("t5_ack_c1", {31'b0, ack[2]}, 32'd0);
        @(posedge clk); #1;
        rst = 1'b1;
        check("t5_ack_c2", {31'b0, ack[2]}, 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        check("t5_ack_c3", {31'b0, ack[2]}, 32'd0);
        check("t5_rdata_zero", rdata[2], 32'h0);
        check("t5_rdata0_zero", rdata[0], 32'h0);
        for (int c = 4; c <= 7; c++) begin
            @(posedge clk); #1;
            check($sformatf("t5_ack_c%0d", c), {31'b0, ack[2]}, 32'd0);
        end
        rd_chk(2, 32'h60, 32'h0BAD_F00D, 1'b0, "t5_rd1");

        // rst and req together: request is not captured
        wr_chk(0, 32'h100, 4'b1111, 32'h0000_0000, 1'b0, "t5b_pre");
        @(posedge clk); #1;
        rst = 1'b1;
        req[0] = 1'b1; rnw[0] = 1'b0; addr[0] = 32'h100; wmask[0] = 4'hF; wdata[0] = 32'hA5A5_A5A5;
        @(posedge clk); #1;
        rst = 1'b0; req[0] = 1'b0;
        for (int c = 1; c <= 3; c++) begin
            @(posedge clk); #1;
            check($sformatf("t5b_ack_c%0d", c), {31'b0, ack[0]}, 32'd0);
        end
        rd_chk(0, 32'h100, 32'h0000_0000, 1'b0, "t5b_rd");

        // 6: address one past the window
        wr_chk(0, 32'h0, 4'b1111, 32'h0101_0101, 1'b0, "t6_pre");
        wr_chk(0, 32'h1000, 4'b1111, 32'hFFFF_FFFF, BOUNDS, "t6_wr");
        rd_chk(0, 32'h0, BOUNDS ? 32'h0101_0101 : 32'hFFFF_FFFF, 1'b0, "t6_rd0");
        rd_chk(0, 32'h1000, BOUNDS ? 32'h0 : 32'hFFFF_FFFF, BOUNDS, "t6_rdoob");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
